det_matrix_loader: RTL and testbench
====================================

Name: det_matrix_loader

Overview:
- Host-side front end for the 5x5 determinant core (mod_det_5x5).
- Accepts matrix elements serially on a valid/ready stream and packs them row-major into a parallel bus for the core's a..y inputs.
- Pulses the core's start, waits for done with a timeout, then returns the 16-bit result on a valid/ready response channel.

Parameters:
N, 5, matrix order; element count = N*N.
TIMEOUT, 1024, max cycles spent in WAIT before the error is flagged; must be >= 2.
CNT_W, 11, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
clr  in  1  synchronous abort; returns the block to LOAD with index 0
in_data  in  8  signed matrix element
in_valid  in  1  in_data valid
in_ready  out  1  element accepted when in_valid && in_ready
mat_flat  out  8*N*N  packed matrix; element k (row-major, k=0 is a) at bits [8k+7:8k]
det_start  out  1  one-cycle start pulse to the core
det_done  in  1  core completion
det_result  in  16  signed core result, valid while det_done=1
res_data  out  16  signed determinant
res_err  out  1  1 = timeout; res_data forced to 0
res_valid  out  1  response valid
res_ready  in  1  response consumed when res_valid && res_ready
busy  out  1  high in START and WAIT

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=LOAD, idx=0, timer=0, mat_flat=0.
  - det_start=0, res_data=0, res_err=0, res_valid=0, busy=0.
  - in_ready goes high from the first cycle after reset releases.
- States:
  - LOAD: in_ready=1. Each accepted element writes mat_flat element idx, then idx++. Accepting element N*N-1 sets idx=0 and moves to START.
  - START: det_start=1 for exactly this one cycle. timer is cleared. Next state is WAIT.
  - WAIT: timer increments each cycle. det_start=0.
    - If det_done=1: capture det_result into res_data, set res_err=0, go to RESP.
    - Else if timer==TIMEOUT-1: set res_data=0, res_err=1, go to RESP.
    - If both occur in the same cycle, det_done wins.
  - RESP: res_valid=1. res_data and res_err are held stable until res_ready=1. The handshake cycle clears res_valid and moves to LOAD.
- Output gating:
  - in_ready=0 in START, WAIT and RESP.
  - det_done is ignored outside WAIT. The START cycle is excluded, so a stuck-high done cannot complete early.
- mat_flat changes only on accepted writes in LOAD. It is stable from START through RESP. It keeps the previous matrix's elements until they are overwritten.
- Latency:
  - Last element accepted at edge T: det_start high during cycle T+1, WAIT entered at T+2.
  - det_done sampled at edge D: res_valid high from cycle D+1.
  - Minimum gap from last accept to res_valid is 3 cycles.
- Throughput:
  - One element per cycle in LOAD.
  - New elements are accepted in the cycle after the response handshake.
- clr has priority over everything except rst_n, in any state:
  - state=LOAD, idx=0, timer=0, res_valid=0, res_err=0, det_start=0.
  - mat_flat is retained.
  - An element presented in the same cycle as clr is not accepted. in_ready may be high, but clr overrides the write.
- Reset or clr in WAIT abandons the operation. A later det_done from the core is ignored because the block is in LOAD.
- Arithmetic:
  - No arithmetic on data paths. in_data is stored bit-exact; det_result is passed through bit-exact.
  - The timer saturates by construction because the state exits at TIMEOUT-1.

Test Plan:
1. Reset then load the 5x5 matrix (rows 1,2,2,2,1 / 2,1,2,2,1 / 1,2,3,1,2 / 2,2,1,2,1 / 2,1,1,1,2), in_valid held high, mod_det_5x5 attached -> det_start one pulse at cycle 26 after first accept, res_valid with res_data=6, res_err=0; mat_flat[7:0]=1 and mat_flat[199:192]=2.
2. Gapped input, in_valid toggling every other cycle, with a stub core returning done after 7 cycles and result -300 -> exactly 25 accepts, res_data=16'hFED4, res_valid exactly 1 cycle after done.
3. Stub core never asserts done, TIMEOUT=16 -> res_valid 16 cycles after WAIT entry, res_err=1, res_data=0; next matrix is accepted normally.
4. res_ready held low for 10 cycles in RESP -> res_valid, res_data and res_err stable, in_ready=0 throughout; one-cycle res_ready -> LOAD next cycle, in_ready=1.
5. clr asserted after 12 elements, then 25 fresh elements -> idx restarts at 0, a single det_start, result corresponds to the new matrix. Separately, clr during WAIT followed by a late det_done -> no res_valid.
6. rst_n low for 1 cycle mid-WAIT with det_done held high through the reset and START cycles -> all outputs return to reset values; after the next full load, completion happens only on a det_done sampled in WAIT.

Source files
------------

// File: rtl/det_matrix_loader_if.sv
// rtl/det_matrix_loader_if.sv - element stream, core handshake and response bundle for det_matrix_loader
// master drives elements, core replies and response ready; slave is the loader itself.
interface det_matrix_loader_if #(
  parameter int N = 5
);
  logic                 clr;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [8*N*N-1:0]     mat_flat;
  logic                 det_start;
  logic                 det_done;
  logic [15:0]          det_result;
  logic [15:0]          res_data;
  logic                 res_err;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;

  modport master (
    output clr, in_data, in_valid, det_done, det_result, res_ready,
    input  in_ready, mat_flat, det_start, res_data, res_err, res_valid, busy
  );

  modport slave (
    input  clr, in_data, in_valid, det_done, det_result, res_ready,
    output in_ready, mat_flat, det_start, res_data, res_err, res_valid, busy
  );
endinterface

// File: rtl/det_matrix_loader.sv
// rtl/det_matrix_loader.sv - serial-to-parallel matrix loader and start/wait/respond sequencer
// Elements are packed row-major into mat_flat; the core result returns on a valid/ready channel.
module det_matrix_loader #(
  parameter int N       = 5,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  det_matrix_loader_if.slave    bus
);
  localparam int NE    = N * N;
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   timer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= LOAD;
      idx           <= '0;
      timer         <= '0;
      bus.mat_flat  <= '0;
      bus.det_start <= 1'b0;
      bus.res_data  <= '0;
      bus.res_err   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else if (bus.clr) begin
      // Abort keeps mat_flat so a partial reload overwrites in place.
      state         <= LOAD;
      idx           <= '0;
      timer         <= '0;
      bus.det_start <= 1'b0;
      bus.res_err   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            for (int k = 0; k < NE; k++) begin
              if (idx == IDX_W'(k)) bus.mat_flat[8*k +: 8] <= bus.in_data;
            end
            if (idx == IDX_W'(NE - 1)) begin
              idx           <= '0;
              state         <= START;
              bus.det_start <= 1'b1;
              bus.busy      <= 1'b1;
              bus.in_ready  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          bus.det_start <= 1'b0;
          timer         <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // A done in the same cycle as the timeout still wins.
          if (bus.det_done) begin
            bus.res_data  <= bus.det_result;
            bus.res_err   <= 1'b0;
            bus.res_valid <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= RESP;
          end else if (timer == CNT_W'(TIMEOUT - 1)) begin
            bus.res_data  <= '0;
            bus.res_err   <= 1'b1;
            bus.res_valid <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_det_matrix_loader.sv
// tb/tb_det_matrix_loader.sv - directed bench for det_matrix_loader with a stub determinant core
// Runs with TIMEOUT=16 so the timeout path is reached quickly.
module tb_det_matrix_loader;
  typedef logic [7:0] mat_t [25];

  logic clk = 1'b0;
  logic rst_n;

  det_matrix_loader_if #(.N(5)) bus ();

  det_matrix_loader #(.N(5), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          stub_cnt  = 0;
  bit          stub_en;
  int          stub_delay;
  logic [15:0] stub_result;
  logic        stub_done = 1'b0;
  logic        force_done;

  assign bus.det_done   = stub_done | force_done;
  assign bus.det_result = stub_result;

  // Stub core: done pulses stub_delay cycles after sampling det_start.
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (bus.det_start && stub_en) stub_cnt <= stub_delay;
    else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= 1'b1;
    end
    if (bus.det_start) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] pack(input mat_t m);
    logic [199:0] p;
    for (int k = 0; k < 25; k++) p[8*k +: 8] = m[k];
    return p;
  endfunction

  task automatic load(input mat_t m, input int n, input bit gapped);
    int  k   = 0;
    int  cyc = 0;
    bit  acc;
    while (k < n && cyc < 200) begin
      bus.in_valid = gapped ? (cyc % 2 == 0) : 1'b1;
      bus.in_data  = m[k];
      acc = bus.in_valid && bus.in_ready;
      tick();
      cyc++;
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    if (k < n) chk("load_timeout", 200'(k), 200'(n));
  endtask

  task automatic wait_resp(input int bound, output int n);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (bus.res_valid !== 1'b1) chk("resp_timeout", 200'(bus.res_valid), 200'(1));
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_valid_clr"}, 200'(bus.res_valid), 200'(0));
    chk({tag, "_in_ready"}, 200'(bus.in_ready), 200'(1));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  200'(bus.in_ready),  200'(1));
    chk({tag, "_det_start"}, 200'(bus.det_start), 200'(0));
    chk({tag, "_res_valid"}, 200'(bus.res_valid), 200'(0));
    chk({tag, "_res_err"},   200'(bus.res_err),   200'(0));
    chk({tag, "_res_data"},  200'(bus.res_data),  200'(0));
    chk({tag, "_busy"},      200'(bus.busy),      200'(0));
    chk({tag, "_mat_flat"},  bus.mat_flat,        200'(0));
  endtask

  initial begin
    mat_t m1, m2, m3, m4;
    int   n, s0;
    bit   ok, seen;
    logic [199:0] snap;

    m1 = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd1,
           8'd2, 8'd1, 8'd2, 8'd2, 8'd1,
           8'd1, 8'd2, 8'd3, 8'd1, 8'd2,
           8'd2, 8'd2, 8'd1, 8'd2, 8'd1,
           8'd2, 8'd1, 8'd1, 8'd1, 8'd2};
    m2 = '{8'd3, 8'hFF, 8'd4, 8'd1, 8'd5,
           8'd9, 8'd2, 8'd6, 8'd5, 8'd3,
           8'd5, 8'd8, 8'd9, 8'd7, 8'd9,
           8'd3, 8'd2, 8'd3, 8'd8, 8'd4,
           8'd6, 8'd2, 8'h80, 8'd4, 8'h7F};
    for (int k = 0; k < 25; k++) begin
      m3[k] = 8'(10 + k);
      m4[k] = 8'(8'hA0 + k);
    end

    rst_n = 1'b0;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.res_ready = 1'b0;
    stub_en = 1'b1; stub_delay = 3; stub_result = 16'd6; force_done = 1'b0;
    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();
    chk("rst_rel_in_ready", 200'(bus.in_ready), 200'(1));

    // Back-to-back load, 25th accept followed by the start pulse
    s0 = start_cnt;
    load(m1, 25, 1'b0);
    chk("t1_det_start",   200'(bus.det_start), 200'(1));
    chk("t1_busy",        200'(bus.busy),      200'(1));
    chk("t1_in_ready",    200'(bus.in_ready),  200'(0));
    chk("t1_mat_flat",    bus.mat_flat,        pack(m1));
    snap = bus.mat_flat;
    chk("t1_elem0",       200'(snap[7:0]),     200'(1));
    chk("t1_elem24",      200'(snap[199:192]), 200'(2));
    tick();
    chk("t1_start_pulse", 200'(bus.det_start), 200'(0));
    wait_resp(20, n);
    chk("t1_res_data",    200'(bus.res_data),  200'(16'd6));
    chk("t1_res_err",     200'(bus.res_err),   200'(0));
    chk("t1_busy_resp",   200'(bus.busy),      200'(0));
    chk("t1_starts",      200'(start_cnt - s0), 200'(1));
    handshake("t1");

    // Gapped input, result one cycle after done
    stub_delay = 7; stub_result = 16'hFED4;
    load(m2, 25, 1'b1);
    chk("t2_det_start", 200'(bus.det_start), 200'(1));
    chk("t2_mat_flat",  bus.mat_flat,        pack(m2));
    n = 0;
    while (bus.det_done !== 1'b1 && n < 30) begin tick(); n++; end
    chk("t2_done_seen",  200'(bus.det_done),  200'(1));
    chk("t2_pre_valid",  200'(bus.res_valid), 200'(0));
    tick();
    chk("t2_res_valid",  200'(bus.res_valid), 200'(1));
    chk("t2_res_data",   200'(bus.res_data),  200'(16'hFED4));
    chk("t2_res_err",    200'(bus.res_err),   200'(0));
    handshake("t2");

    // Timeout: 16 cycles in WAIT, then a normal matrix
    stub_en = 1'b0;
    load(m1, 25, 1'b0);
    tick();
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("t3_wait_cycles", 200'(n),            200'(16));
    chk("t3_res_err",     200'(bus.res_err),  200'(1));
    chk("t3_res_data",    200'(bus.res_data), 200'(0));
    handshake("t3");
    stub_en = 1'b1; stub_delay = 3; stub_result = 16'd77;
    load(m2, 25, 1'b0);
    wait_resp(20, n);
    chk("t3_next_data", 200'(bus.res_data), 200'(16'd77));
    chk("t3_next_err",  200'(bus.res_err),  200'(0));
    handshake("t3b");

    // Back-pressure on the response
    stub_result = 16'hFFFB;
    load(m3, 25, 1'b0);
    wait_resp(20, n);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(bus.res_valid === 1'b1 && bus.res_data === 16'hFFFB &&
            bus.res_err === 1'b0 && bus.in_ready === 1'b0)) ok = 1'b0;
    end
    chk("t4_hold_stable", 200'(ok), 200'(1));
    handshake("t4");

    // clr after 12 elements, presented element dropped, fresh reload
    stub_result = 16'h0042;
    load(m2, 12, 1'b0);
    bus.clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55;
    tick();
    bus.clr = 1'b0; bus.in_valid = 1'b0;
    snap = bus.mat_flat;
    chk("t5_in_ready",  200'(bus.in_ready),   200'(1));
    chk("t5_elem11",    200'(snap[95:88]),    200'(m2[11]));
    chk("t5_elem12",    200'(snap[103:96]),   200'(m3[12]));
    s0 = start_cnt;
    load(m4, 25, 1'b0);
    chk("t5_mat_flat",  bus.mat_flat,         pack(m4));
    wait_resp(20, n);
    chk("t5_res_data",  200'(bus.res_data),   200'(16'h0042));
    chk("t5_starts",    200'(start_cnt - s0), 200'(1));
    handshake("t5");

    // clr during WAIT, late done ignored
    stub_delay = 7;
    load(m1, 25, 1'b0);
    tick(); tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("t5w_busy", 200'(bus.busy), 200'(0));
    ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.det_done === 1'b1) seen = 1'b1;
      if (bus.res_valid !== 1'b0) ok = 1'b0;
    end
    chk("t5w_late_done", 200'(seen), 200'(1));
    chk("t5w_no_valid",  200'(ok),   200'(1));

    // Reset mid-WAIT with done stuck high through reset and START
    stub_en = 1'b0;
    load(m2, 25, 1'b0);
    tick(); tick();
    rst_n = 1'b0; force_done = 1'b1;
    tick();
    rst_n = 1'b1;
    chk_reset("t6");
    stub_result = 16'h0123;
    load(m1, 25, 1'b0);
    chk("t6_det_start",  200'(bus.det_start), 200'(1));
    chk("t6_load_valid", 200'(bus.res_valid), 200'(0));
    tick();
    chk("t6_start_ign",  200'(bus.res_valid), 200'(0));
    tick();
    chk("t6_res_valid",  200'(bus.res_valid), 200'(1));
    chk("t6_res_data",   200'(bus.res_data),  200'(16'h0123));
    force_done = 1'b0;
    handshake("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
